// File: rtl/valid_ready_pkg.sv
// Shared definitions for the byte-serial valid/ready split and accumulate blocks.
package valid_ready_pkg;

  localparam int DEFAULT_NUM_BYTES = 4;
  localparam int DEFAULT_BYTE_W    = 8;
  localparam int DEFAULT_SUM_W     = DEFAULT_BYTE_W + $clog2(DEFAULT_NUM_BYTES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Running-sum width that holds NUM_BYTES*(2^BYTE_W-1) without wrapping.
  function automatic int sum_width(input int byte_w, input int num_bytes);
    return byte_w + $clog2(num_bytes);
  endfunction

endpackage

// File: rtl/valid_ready_split_if.sv
// Upstream word port plus downstream byte port of the width-down converter.
interface valid_ready_split_if #(
  parameter int NUM_BYTES = 4,
  parameter int BYTE_W    = 8
);
  localparam int WORD_W = NUM_BYTES * BYTE_W;
  localparam int SUM_W  = BYTE_W + $clog2(NUM_BYTES);

  logic [WORD_W-1:0] data_in;
  logic              valid_a;
  logic              ready_a;
  logic              valid_b;
  logic              ready_b;
  logic [BYTE_W-1:0] data_out;
  logic              last_b;
  logic [SUM_W-1:0]  sum_b;

  // slave: the converter itself; master: the producer/consumer environment around it.
  modport slave (
    input  data_in, valid_a, ready_b,
    output ready_a, valid_b, data_out, last_b, sum_b
  );

  modport master (
    output data_in, valid_a, ready_b,
    input  ready_a, valid_b, data_out, last_b, sum_b
  );

endinterface

// File: rtl/valid_ready_split.sv
// Width-down converter: one NUM_BYTES-byte word in, NUM_BYTES single-byte beats out,
// each beat tagged with a last flag and the running sum of the word so far.
module valid_ready_split
  import valid_ready_pkg::*;
#(
  parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
  parameter int BYTE_W    = DEFAULT_BYTE_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  valid_ready_split_if.slave  bus
);

  localparam int WORD_W = NUM_BYTES * BYTE_W;
  localparam int SUM_W  = sum_width(BYTE_W, NUM_BYTES);
  localparam int CNT_W  = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [SUM_W-1:0]  sum_q, sum_d;

  logic              valid_b;
  logic              last_b;
  logic              ready_a;
  logic              up_acc;
  logic              dn_acc;
  logic [BYTE_W-1:0] load_byte;
  logic [WORD_W-1:0] load_rest;
  logic [BYTE_W-1:0] next_byte;
  logic [WORD_W-1:0] next_rest;

  // The outgoing byte always sits at the shift-out end; the rest of the word trails it.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign load_byte = bus.data_in[BYTE_W-1:0];
      assign load_rest = bus.data_in >> BYTE_W;
      assign next_byte = shift_q[BYTE_W-1:0];
      assign next_rest = shift_q >> BYTE_W;
    end else begin : g_msb_first
      assign load_byte = bus.data_in[WORD_W-1 -: BYTE_W];
      assign load_rest = bus.data_in << BYTE_W;
      assign next_byte = shift_q[WORD_W-1 -: BYTE_W];
      assign next_rest = shift_q << BYTE_W;
    end
  endgenerate

  assign valid_b = (state_q == SEND);
  assign last_b  = valid_b && (cnt_q == CNT_LAST);
  assign dn_acc  = valid_b && bus.ready_b;
  // Accepting on the last taken byte lets consecutive words stream with no bubble.
  assign ready_a = (state_q == IDLE) || (dn_acc && last_b);
  assign up_acc  = bus.valid_a && ready_a;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    sum_d   = sum_q;

    unique case (state_q)
      IDLE: begin
        if (up_acc) begin
          state_d = SEND;
          cnt_d   = '0;
          shift_d = load_rest;
          data_d  = load_byte;
          sum_d   = SUM_W'(load_byte);
        end
      end
      SEND: begin
        if (dn_acc) begin
          if (last_b) begin
            if (up_acc) begin
              state_d = SEND;
              cnt_d   = '0;
              shift_d = load_rest;
              data_d  = load_byte;
              sum_d   = SUM_W'(load_byte);
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = next_rest;
            data_d  = next_byte;
            sum_d   = sum_q + SUM_W'(next_byte);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.ready_a  = ready_a;
  assign bus.valid_b  = valid_b;
  assign bus.data_out = data_q;
  assign bus.last_b   = last_b;
  assign bus.sum_b    = sum_q;

endmodule

// File: tb/tb_valid_ready_split.sv
// Bench for valid_ready_split: LSB-first and MSB-first instances, directed scenarios plus
// randomized traffic scored against a queue-of-beats model built from the word arithmetic.
module tb_valid_ready_split;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [9:0] sum;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din [2];
  logic        va  [2];
  logic        rb  [2];
  logic        ra  [2];
  logic        vb  [2];
  logic        lb  [2];
  logic [7:0]  dout[2];
  logic [9:0]  sb  [2];

  int    n_checks = 0;
  int    n_pass   = 0;
  int    beats_seen [2];
  beat_t expq [2][$];

  valid_ready_split_if #(.NUM_BYTES(4), .BYTE_W(8)) if_l ();
  valid_ready_split_if #(.NUM_BYTES(4), .BYTE_W(8)) if_m ();

  valid_ready_split #(.NUM_BYTES(4), .BYTE_W(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bus(if_l)
  );
  valid_ready_split #(.NUM_BYTES(4), .BYTE_W(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bus(if_m)
  );

  assign if_l.data_in = din[0];
  assign if_l.valid_a = va[0];
  assign if_l.ready_b = rb[0];
  assign if_m.data_in = din[1];
  assign if_m.valid_a = va[1];
  assign if_m.ready_b = rb[1];
  assign ra[0] = if_l.ready_a;   assign ra[1] = if_m.ready_a;
  assign vb[0] = if_l.valid_b;   assign vb[1] = if_m.valid_b;
  assign lb[0] = if_l.last_b;    assign lb[1] = if_m.last_b;
  assign dout[0] = if_l.data_out; assign dout[1] = if_m.data_out;
  assign sb[0] = if_l.sum_b;     assign sb[1] = if_m.sum_b;

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: an accepted word expands into its byte beats, in port order, with running sums.
  task automatic push_word(input int idx, input logic [31:0] w);
    int    s;
    int    pos;
    int    b;
    beat_t e;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      pos = (idx == 0) ? i : 3 - i;
      b = int'((w >> (8 * pos)) & 32'hFF);
      s = s + b;
      e.data = 8'(b);
      e.last = (i == 3);
      e.sum  = 10'(s);
      expq[idx].push_back(e);
    end
  endtask

  task automatic sb_step(input int idx);
    bit ev;
    bit er;
    ev = (expq[idx].size() > 0);
    er = !ev || (rb[idx] && expq[idx][0].last);
    n_checks++;
    if (vb[idx] !== ev || (!ev && lb[idx] !== 1'b0)) begin
      $display("FAIL sb_valid[%0d] t=%0t: valid_b=%b last_b=%b, expected valid_b=%b", idx, $time, vb[idx], lb[idx], ev);
    end else n_pass++;
    if (ev) begin
      n_checks++;
      if (dout[idx] !== expq[idx][0].data || lb[idx] !== expq[idx][0].last || sb[idx] !== expq[idx][0].sum)
        $display("FAIL sb_beat[%0d] t=%0t: data=%h last=%b sum=%0d, expected data=%h last=%b sum=%0d",
                 idx, $time, dout[idx], lb[idx], sb[idx], expq[idx][0].data, expq[idx][0].last, expq[idx][0].sum);
      else n_pass++;
    end
    n_checks++;
    if (ra[idx] !== er) $display("FAIL sb_ready_a[%0d] t=%0t: ready_a=%b, expected %b", idx, $time, ra[idx], er);
    else n_pass++;
    if (ev && rb[idx]) begin
      void'(expq[idx].pop_front());
      beats_seen[idx]++;
    end
    if (va[idx] && er) push_word(idx, din[idx]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expq[0].delete();
        expq[1].delete();
      end else begin
        sb_step(0);
        sb_step(1);
      end
    end
  end

  // Present a word and hold it until accepted; returns at the input-drive point after the accept edge.
  task automatic drive_word(input int idx, input logic [31:0] w, output bit ok);
    din[idx] = w;
    va[idx]  = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (ra[idx] === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL accept_timeout[%0d]: word %h never accepted, expected accept within 200 cycles", idx, w);
    end
  endtask

  task automatic wait_idle(input int idx);
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 200 && !idle; c++) begin
      @(negedge clk);
      if (vb[idx] === 1'b0 && expq[idx].size() == 0) idle = 1'b1;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (!idle) $display("FAIL drain_timeout[%0d]: valid_b=%b pending=%0d, expected idle", idx, vb[idx], expq[idx].size());
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (vb[i] !== 1'b0 || dout[i] !== 8'h00 || lb[i] !== 1'b0 || sb[i] !== 10'd0 || ra[i] !== 1'b1)
        $display("FAIL reset_values[%0d]: valid_b=%b data=%h last=%b sum=%0d ready_a=%b, expected 0 00 0 0 1",
                 i, vb[i], dout[i], lb[i], sb[i], ra[i]);
      else n_pass++;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    int s;
    rb[0] = 1'b1;
    drive_word(0, 32'h04030201, ok);
    va[0] = 1'b0;
    din[0] = $urandom;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s = s + i + 1;
      n_checks++;
      if (vb[0] !== 1'b1 || dout[0] !== 8'(i + 1) || sb[0] !== 10'(s) || lb[0] !== (i == 3))
        $display("FAIL basic_beat%0d: valid=%b data=%h sum=%0d last=%b, expected 1 %h %0d %b",
                 i, vb[0], dout[0], sb[0], lb[0], 8'(i + 1), s, (i == 3));
      else n_pass++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_checks++;
    if (vb[0] !== 1'b0) $display("FAIL basic_idle: valid_b=%b, expected 0", vb[0]);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int s;
    int acc_at;
    rb[0] = 1'b1;
    drive_word(0, 32'h04030201, ok);
    din[0] = 32'h08070605;
    acc_at = -1;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) s = 0;
      s = s + i + 1;
      n_checks++;
      if (vb[0] !== 1'b1 || dout[0] !== 8'(i + 1) || sb[0] !== 10'(s))
        $display("FAIL b2b_beat%0d: valid=%b data=%h sum=%0d, expected 1 %h %0d", i, vb[0], dout[0], sb[0], 8'(i + 1), s);
      else n_pass++;
      if (va[0] && ra[0] === 1'b1) acc_at = i;
      @(posedge clk);
      #1;
      if (acc_at == i) va[0] = 1'b0;
    end
    n_checks++;
    if (acc_at != 3) $display("FAIL b2b_accept_cycle: second word accepted at beat %0d, expected 3", acc_at);
    else n_pass++;
    wait_idle(0);
  endtask

  task automatic test_backpressure();
    bit ok;
    rb[0] = 1'b1;
    drive_word(0, 32'h04030201, ok);
    va[0] = 1'b0;
    @(posedge clk);
    #1 rb[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (vb[0] !== 1'b1 || dout[0] !== 8'h02 || sb[0] !== 10'd3 || ra[0] !== 1'b0 || lb[0] !== 1'b0)
        $display("FAIL stall%0d: valid=%b data=%h sum=%0d ready_a=%b last=%b, expected 1 02 3 0 0",
                 i, vb[0], dout[0], sb[0], ra[0], lb[0]);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    rb[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (dout[0] !== 8'h03 || sb[0] !== 10'd6) $display("FAIL stall_resume: data=%h sum=%0d, expected 03 6", dout[0], sb[0]);
    else n_pass++;
    wait_idle(0);
  endtask

  task automatic test_max_sum();
    bit ok;
    rb[0] = 1'b1;
    drive_word(0, 32'hFFFFFFFF, ok);
    va[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (dout[0] !== 8'hFF || sb[0] !== 10'(255 * (i + 1)))
        $display("FAIL max_sum%0d: data=%h sum=%0d, expected ff %0d", i, dout[0], sb[0], 255 * (i + 1));
      else n_pass++;
      @(posedge clk);
      #1;
    end
    wait_idle(0);
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    rb[0] = 1'b1;
    drive_word(0, 32'h04030201, ok);
    va[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (vb[0] !== 1'b0 || sb[0] !== 10'd0 || dout[0] !== 8'h00 || lb[0] !== 1'b0 || ra[0] !== 1'b1)
      $display("FAIL reset_mid_word: valid=%b sum=%0d data=%h last=%b ready_a=%b, expected 0 0 00 0 1",
               vb[0], sb[0], dout[0], lb[0], ra[0]);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_word(0, 32'h00000009, ok);
    va[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (dout[0] !== ((i == 0) ? 8'h09 : 8'h00) || sb[0] !== 10'd9)
        $display("FAIL post_reset%0d: data=%h sum=%0d, expected %h 9", i, dout[0], sb[0], (i == 0) ? 8'h09 : 8'h00);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    wait_idle(0);
  endtask

  task automatic test_msb_first();
    bit ok;
    int s;
    rb[1] = 1'b1;
    drive_word(1, 32'h04030201, ok);
    va[1] = 1'b0;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s = s + 4 - i;
      n_checks++;
      if (dout[1] !== 8'(4 - i) || sb[1] !== 10'(s) || lb[1] !== (i == 3))
        $display("FAIL msb_beat%0d: data=%h sum=%0d last=%b, expected %h %0d %b", i, dout[1], sb[1], lb[1], 8'(4 - i), s, (i == 3));
      else n_pass++;
      @(posedge clk);
      #1;
    end
    wait_idle(1);
  endtask

  task automatic test_random(input int idx, input int n_words);
    bit done;
    bit ok;
    int start;
    done  = 1'b0;
    start = beats_seen[idx];
    fork
      begin
        for (int w = 0; w < n_words; w++) begin
          va[idx] = 1'b0;
          repeat ($urandom_range(0, 3)) begin
            din[idx] = $urandom;
            @(posedge clk);
            #1;
          end
          drive_word(idx, $urandom, ok);
        end
        va[idx]  = 1'b0;
        din[idx] = $urandom;
        done = 1'b1;
      end
      begin
        while (!done) begin
          rb[idx] = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    rb[idx] = 1'b1;
    wait_idle(idx);
    n_checks++;
    if (beats_seen[idx] - start != 4 * n_words)
      $display("FAIL random_beats[%0d]: %0d beats, expected %0d", idx, beats_seen[idx] - start, 4 * n_words);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      din[i] = '0;
      va[i]  = 1'b0;
      rb[i]  = 1'b0;
      beats_seen[i] = 0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_max_sum();
    test_reset_mid_word();
    test_msb_first();
    test_random(0, 150);
    test_random(1, 150);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
